// File: rtl/four_bank_mem_if.sv
// Request/response bundle for four_bank_mem.
// The requester drives the master side; the memory sits on the slave side.
interface four_bank_mem_if;
   logic [15:0] addr;
   logic [15:0] data_in;
   logic        wr;
   logic        rd;
   logic [15:0] data_out;
   logic        stall;
   logic [3:0]  busy;
   logic        err;

   modport master (
      output addr, data_in, wr, rd,
      input  data_out, stall, busy, err
   );

   modport slave (
      input  addr, data_in, wr, rd,
      output data_out, stall, busy, err
   );
endinterface

// File: rtl/four_bank_mem.sv
// Four-bank interleaved 16-bit word memory.
// Bank = addr[2:1], so consecutive words land in different banks.
// Each bank is occupied for 4 cycles after accepting a request.
// Reads return on a fixed 2-cycle pipeline.
// Illegal requests raise a one-cycle err pulse.
// DEPTH_LOG2 must be in the range 3..14.
module four_bank_mem #(
   parameter int DEPTH_LOG2 = 8
) (
   input  logic           clk,
   input  logic           rst,
   four_bank_mem_if.slave bus
);
   // The word index is {row, bank}; each bank stores one row per index value.
   localparam int IDX_W      = DEPTH_LOG2 - 2;
   localparam int BANK_WORDS = 1 << IDX_W;

   logic             w_req;
   logic             w_legal;
   logic             w_illegal;
   logic             w_stall;
   logic             w_accept;
   logic             w_acc_rd;
   logic             w_acc_wr;
   logic [1:0]       w_bank;
   logic [IDX_W-1:0] w_idx;
   logic [3:0]       w_busy;
   logic [15:0]      w_bank_rdata [4];
   logic             w_unused_addr;

   logic             r_rd_vld1;
   logic [1:0]       r_rd_bank1;
   logic [15:0]      r_data_out;
   logic             r_err;

   // Address decode. Bits above DEPTH_LOG2 are dropped, so addresses wrap.
   assign w_bank        = bus.addr[2:1];
   assign w_idx         = bus.addr[DEPTH_LOG2:3];
   assign w_unused_addr = ^bus.addr[15:DEPTH_LOG2+1];

   // Request classification.
   // A request is legal only with exactly one of rd/wr set
   // and a word-aligned (even) address.
   assign w_req     = bus.rd | bus.wr;
   assign w_legal   = (bus.rd ^ bus.wr) & ~bus.addr[0];
   assign w_illegal = (bus.rd & bus.wr) | (w_req & bus.addr[0]);

   // Stall applies to any request aimed at a busy bank, illegal ones included.
   // As a result, an illegal request's error is held back until its bank frees up.
   assign w_stall  = w_req & w_busy[w_bank];
   assign w_accept = w_legal & ~w_stall;
   assign w_acc_rd = w_accept & bus.rd;
   assign w_acc_wr = w_accept & bus.wr;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_bank
         logic [15:0] r_mem [BANK_WORDS];
         logic [15:0] r_rdata;
         logic [1:0]  r_cnt;
         logic        w_sel;

         assign w_sel = (w_bank == 2'(gi));

         // Bank storage with a registered read port.
         // This is the first read stage and is left unreset, so it maps onto block RAM.
         always_ff @(posedge clk) begin
            if (w_acc_wr && w_sel) begin
               r_mem[w_idx] <= bus.data_in;
            end
            if (w_acc_rd && w_sel) begin
               r_rdata <= r_mem[w_idx];
            end
         end

         // Occupancy counter: loads 3 on accept, then counts down to idle.
         // An accept only happens while the counter is zero,
         // so a load never collides with a decrement.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               r_cnt <= 2'd0;
            end else if (w_accept && w_sel) begin
               r_cnt <= 2'd3;
            end else if (r_cnt != 2'd0) begin
               r_cnt <= r_cnt - 2'd1;
            end
         end

         assign w_busy[gi]       = (r_cnt != 2'd0);
         assign w_bank_rdata[gi] = r_rdata;
      end
   endgenerate

   // Read pipeline stage 1: remember which bank holds the returning word.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rd_vld1  <= 1'b0;
         r_rd_bank1 <= 2'd0;
      end else begin
         r_rd_vld1  <= w_acc_rd;
         r_rd_bank1 <= w_bank;
      end
   end

   // Read pipeline stage 2: present the word for one cycle, otherwise drive zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_data_out <= 16'h0000;
      end else begin
         r_data_out <= r_rd_vld1 ? w_bank_rdata[r_rd_bank1] : 16'h0000;
      end
   end

   // Error pulse: raised in the cycle after an illegal request that was not stalled.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_err <= 1'b0;
      end else begin
         r_err <= w_illegal & ~w_stall;
      end
   end

   assign bus.stall    = w_stall;
   assign bus.busy     = w_busy;
   assign bus.data_out = r_data_out;
   assign bus.err      = r_err;
endmodule

// File: tb/tb_four_bank_mem.sv
// Testbench for four_bank_mem: directed scenarios followed by random traffic.
// Outputs are compared against a cycle-indexed behavioural model.
module tb_four_bank_mem;
   localparam int DEPTH_LOG2 = 8;
   localparam int WORDS      = 1 << DEPTH_LOG2;

   logic clk;
   logic rst;

   four_bank_mem_if bus();

   four_bank_mem #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state.
   // A bank may accept again at cycle next_free[b]; expected outputs are keyed by cycle.
   int          n_checks;
   int          n_pass;
   int          cyc;
   int          next_free [4];
   logic [15:0] mem_m [WORDS];
   bit          written [WORDS];
   logic [15:0] exp_dout [int];
   bit          exp_err [int];

   // The pending request is held on the bus until the model says it has been consumed.
   bit          p_valid;
   bit          p_rd;
   bit          p_wr;
   logic [15:0] p_addr;
   logic [15:0] p_data;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
   endtask

   function automatic int word_of(input logic [15:0] a);
      return (int'(a) / 2) % WORDS;
   endfunction

   function automatic int bank_of(input logic [15:0] a);
      return (int'(a) / 2) % 4;
   endfunction

   // One clock cycle: drive the pending request, check every output, then advance the model.
   task automatic run_cycle();
      bit          req;
      bit          exp_stall;
      logic [3:0]  exp_busy;
      logic [15:0] dexp;
      bit          eexp;
      int          w;
      @(negedge clk);
      bus.rd      = p_valid & p_rd;
      bus.wr      = p_valid & p_wr;
      bus.addr    = p_addr;
      bus.data_in = p_data;
      #1;
      req = p_valid && (p_rd || p_wr);
      for (int b = 0; b < 4; b++) exp_busy[b] = (cyc < next_free[b]);
      exp_stall = req && exp_busy[bank_of(p_addr)];
      dexp = exp_dout.exists(cyc) ? exp_dout[cyc] : 16'h0000;
      eexp = exp_err.exists(cyc);
      chk("stall", 32'(bus.stall), 32'(exp_stall));
      chk("busy", 32'(bus.busy), 32'(exp_busy));
      chk("data_out", 32'(bus.data_out), 32'(dexp));
      chk("err", 32'(bus.err), 32'(eexp));
      if (exp_dout.exists(cyc)) exp_dout.delete(cyc);
      if (exp_err.exists(cyc)) exp_err.delete(cyc);
      if (req && !exp_stall) begin
         w = word_of(p_addr);
         if ((p_rd != p_wr) && (p_addr % 2 == 0)) begin
            next_free[bank_of(p_addr)] = cyc + 4;
            if (p_wr) begin
               mem_m[w]   = p_data;
               written[w] = 1'b1;
               $display("cyc=%0d write addr=%04h data=%04h", cyc, p_addr, p_data);
            end else begin
               exp_dout[cyc + 2] = mem_m[w];
               $display("cyc=%0d read  addr=%04h expect=%04h", cyc, p_addr, mem_m[w]);
            end
         end else begin
            exp_err[cyc + 1] = 1'b1;
            $display("cyc=%0d illegal rd=%0d wr=%0d addr=%04h", cyc, p_rd, p_wr, p_addr);
         end
         p_valid = 1'b0;
      end
      cyc++;
   endtask

   // Hold a request until the model consumes it; the loop is bounded.
   task automatic issue(input bit rd, input bit wr, input logic [15:0] addr, input logic [15:0] data);
      int budget;
      budget  = 0;
      p_valid = 1'b1;
      p_rd    = rd;
      p_wr    = wr;
      p_addr  = addr;
      p_data  = data;
      while (p_valid && budget < 10) begin
         run_cycle();
         budget++;
      end
      p_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      p_valid = 1'b0;
      repeat (n) run_cycle();
   endtask

   // Pulse the reset low partway through the cycle that follows an accepted read.
   task automatic reset_after_read(input logic [15:0] addr);
      issue(1'b1, 1'b0, addr, 16'h0000);
      @(negedge clk);
      bus.rd = 1'b0;
      bus.wr = 1'b0;
      #1 rst = 1'b0;
      #1;
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_data_out", 32'(bus.data_out), 32'd0);
      chk("rst_err", 32'(bus.err), 32'd0);
      for (int b = 0; b < 4; b++) next_free[b] = 0;
      exp_dout.delete();
      exp_err.delete();
      #1 rst = 1'b1;
      cyc++;
   endtask

   initial begin
      int          op;
      int          w;
      bit          sel;
      logic [15:0] a;
      logic [15:0] d;

      n_checks    = 0;
      n_pass      = 0;
      cyc         = 0;
      p_valid     = 1'b0;
      p_rd        = 1'b0;
      p_wr        = 1'b0;
      p_addr      = 16'h0000;
      p_data      = 16'h0000;
      rst         = 1'b0;
      bus.rd      = 1'b0;
      bus.wr      = 1'b0;
      bus.addr    = 16'h0000;
      bus.data_in = 16'h0000;
      for (int b = 0; b < 4; b++) next_free[b] = 0;
      for (int i = 0; i < WORDS; i++) written[i] = 1'b0;

      // Reset state.
      repeat (3) @(negedge clk);
      chk("reset_busy", 32'(bus.busy), 32'd0);
      chk("reset_data_out", 32'(bus.data_out), 32'd0);
      chk("reset_err", 32'(bus.err), 32'd0);
      chk("reset_stall", 32'(bus.stall), 32'd0);
      rst = 1'b1;

      // Write then read back from the same bank: the read stalls until T+4.
      issue(1'b0, 1'b1, 16'h0010, 16'hBEEF);
      issue(1'b1, 1'b0, 16'h0010, 16'h0000);
      idle(3);

      // Fill words in all four banks, then read them back-to-back.
      issue(1'b0, 1'b1, 16'h0000, 16'hA000);
      issue(1'b0, 1'b1, 16'h0002, 16'hA002);
      issue(1'b0, 1'b1, 16'h0004, 16'hA004);
      issue(1'b0, 1'b1, 16'h0006, 16'hA006);
      issue(1'b0, 1'b1, 16'h0018, 16'hA018);
      issue(1'b0, 1'b1, 16'h0020, 16'h1111);
      idle(4);
      issue(1'b1, 1'b0, 16'h0000, 16'h0000);
      issue(1'b1, 1'b0, 16'h0002, 16'h0000);
      issue(1'b1, 1'b0, 16'h0004, 16'h0000);
      issue(1'b1, 1'b0, 16'h0006, 16'h0000);
      idle(5);

      // Same-bank conflict between different words.
      issue(1'b0, 1'b1, 16'h0008, 16'h5A5A);
      issue(1'b1, 1'b0, 16'h0018, 16'h0000);
      idle(4);

      // Illegal requests; storage at 0x0020 must keep 0x1111.
      issue(1'b1, 1'b1, 16'h0020, 16'h2222);
      idle(1);
      issue(1'b1, 1'b0, 16'h0021, 16'h0000);
      idle(1);
      issue(1'b0, 1'b1, 16'h0021, 16'h3333);
      idle(4);
      // Illegal request to a busy bank: its error waits for the stall to clear.
      issue(1'b1, 1'b0, 16'h0020, 16'h0000);
      issue(1'b1, 1'b1, 16'h0020, 16'h4444);
      idle(4);
      issue(1'b1, 1'b0, 16'h0020, 16'h0000);
      idle(4);

      // Reset mid-operation; the stored word survives.
      reset_after_read(16'h0010);
      idle(3);
      issue(1'b1, 1'b0, 16'h0010, 16'h0000);
      idle(3);

      // Address wrap above DEPTH_LOG2.
      issue(1'b0, 1'b1, 16'h0202, 16'h1234);
      idle(3);
      issue(1'b1, 1'b0, 16'h0002, 16'h0000);
      idle(3);

      // Random traffic, mostly within 16 words so bank conflicts are frequent.
      for (int i = 0; i < 400; i++) begin
         op  = $urandom_range(0, 9);
         w   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, WORDS - 1) : $urandom_range(0, 15);
         a   = 16'(($urandom_range(0, 127) << 9) | (w << 1));
         d   = 16'($urandom);
         sel = 1'($urandom_range(0, 1));
         if (op == 0) begin
            if (sel) issue(1'b1, 1'b1, a, d);
            else issue(1'($urandom_range(0, 1)), sel, a, d);
         end else if (op == 1) begin
            issue(sel, !sel, a | 16'h0001, d);
         end else if (op == 2) begin
            idle($urandom_range(1, 2));
         end else if (op <= 5 || !written[w]) begin
            issue(1'b0, 1'b1, a, d);
         end else begin
            issue(1'b1, 1'b0, a, d);
         end
      end
      idle(5);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
